// File: rtl/arb_pkg.sv
// Shared types and sizing for the 4-way round-robin arbiter.
//   NREQ : number of requesters (fixed at 4)
//   IDW  : width of the encoded grant index
//   arb_state_t : arbiter FSM states
package arb_pkg;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
endpackage

// File: rtl/rr_prio_enc_4_2.sv
// Rotating priority encoder: finds the first set request at or above ptr,
// wrapping modulo 4. Purely combinational.
//   req [3:0] : request vector
//   ptr [1:0] : index with highest priority
//   idx [1:0] : winning index (don't-care when any=0)
//   any       : at least one request set
module rr_prio_enc_4_2
  import arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [IDW-1:0]    off;
  logic              found;

  always_comb begin
    // Rotate right by ptr so the priority origin lands on bit 0.
    dbl   = {req, req};
    rot   = NREQ'(dbl >> ptr);
    off   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && rot[i]) begin
        off   = IDW'(i);
        found = 1'b1;
      end
    end
    any = |req;
    idx = off + ptr;  // wraps modulo 4 through the IDW-bit width
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter for 4 requesters with hold-until-release handshake
// and an optional watchdog that forces release after MAX_HOLD cycles.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   en        : allow new grants
//   req [3:0] : requests, held for the whole transaction
//   gnt [3:0] : registered one-hot grant
//   gnt_id    : encoded grant index (0 when idle)
//   gnt_valid : any grant active
//   timeout   : one-cycle pulse in the first cycle after a forced release
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CW       = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_valid,
  output logic            timeout
);

  // With the watchdog off the counter just saturates at all-ones.
  localparam logic [CW-1:0] HOLD_SAT = (MAX_HOLD > 0) ? CW'(MAX_HOLD - 1) : {CW{1'b1}};
  localparam logic          WD_ON    = (MAX_HOLD != 0);

  arb_state_t      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]  id_q, id_d;
  logic            to_q, to_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [CW-1:0]   hold_q, hold_d;

  logic [IDW-1:0]  scan_ptr;
  logic [IDW-1:0]  win;
  logic            any;
  logic            holding;
  logic            forced;

  // While busy, the only scan that matters is the one at release, which
  // starts just past the current holder; that is the future ptr value.
  assign scan_ptr = (state_q == ARB_BUSY) ? id_q + 1'b1 : ptr_q;

  rr_prio_enc_4_2 u_enc (
    .req (req),
    .ptr (scan_ptr),
    .idx (win),
    .any (any)
  );

  assign holding = req[id_q];
  assign forced  = WD_ON && holding && (hold_q == HOLD_SAT);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    to_d    = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        gnt_d = '0;
        id_d  = '0;
        if (en && any) begin
          state_d = ARB_BUSY;
          gnt_d   = NREQ'(1) << win;
          id_d    = win;
          hold_d  = '0;
        end
      end
      ARB_BUSY: begin
        if (holding && !forced) begin
          if (hold_q != HOLD_SAT) hold_d = hold_q + 1'b1;
        end else begin
          ptr_d  = id_q + 1'b1;
          to_d   = forced;
          hold_d = '0;
          if (en && any) begin
            gnt_d = NREQ'(1) << win;
            id_d  = win;
          end else begin
            state_d = ARB_IDLE;
            gnt_d   = '0;
            id_d    = '0;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      to_q    <= 1'b0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      to_q    <= to_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = id_q;
  assign gnt_valid = |gnt_q;
  assign timeout   = to_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Bench for rr_arbiter_4: directed scenarios plus randomized traffic
// checked against a cycle-level reference model.
module tb_rr_arbiter_4;

  localparam int MH = 16;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid, timeout;
  logic [7:0] obs;

  int tests = 0;
  int fails = 0;

  rr_arbiter_4 #(.MAX_HOLD(MH), .CW(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  assign obs = {gnt, gnt_id, gnt_valid, timeout};

  // Reference model: owner index (-1 when idle), priority origin, number of
  // cycles the current grant has been visible, and the timeout pulse.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_len   = 0;
  bit m_to    = 1'b0;

  function automatic int pick(logic [3:0] r, int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_len = 0; m_to = 1'b0;
    end else if (m_owner < 0) begin
      m_to = 1'b0;
      if (en && req != 4'b0) begin
        m_owner = pick(req, m_ptr);
        m_len   = 1;
      end
    end else if (req[m_owner] && m_len < MH) begin
      m_to  = 1'b0;
      m_len = m_len + 1;
    end else begin
      m_to    = req[m_owner];
      m_ptr   = (m_owner + 1) % 4;
      m_owner = (en && req != 4'b0) ? pick(req, m_ptr) : -1;
      m_len   = 1;
    end
  end

  // Expected packed observation {gnt, gnt_id, gnt_valid, timeout}.
  function automatic logic [7:0] exp_of(logic [3:0] g, logic t);
    logic [1:0] id;
    id = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) id = 2'(i);
    return {g, id, |g, t};
  endfunction

  function automatic logic [3:0] model_gnt();
    return (m_owner < 0) ? 4'b0 : 4'(1 << m_owner);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; req = 4'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; req = 4'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++;
      if (obs !== 8'b0) begin
        fails++; $display("FAIL reset_hold: got %b want %b", obs, 8'b0);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (obs !== 8'b0) begin
        fails++; $display("FAIL idle_no_req: got %b want %b", obs, 8'b0);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    tick();
    tests++;
    if (obs !== exp_of(4'b0100, 1'b0)) begin
      fails++; $display("FAIL single_grant: got %b want %b", obs, exp_of(4'b0100, 1'b0));
    end
    tick();
    tests++;
    if (obs !== exp_of(4'b0100, 1'b0)) begin
      fails++; $display("FAIL single_hold: got %b want %b", obs, exp_of(4'b0100, 1'b0));
    end
    req = 4'b0000;
    tick();
    tests++;
    if (obs !== 8'b0) begin
      fails++; $display("FAIL single_release: got %b want %b", obs, 8'b0);
    end
    // ptr should now be 3, so requester 3 wins a full contention.
    req = 4'b1111;
    tick();
    tests++;
    if (obs !== exp_of(4'b1000, 1'b0)) begin
      fails++; $display("FAIL ptr_after_release: got %b want %b", obs, exp_of(4'b1000, 1'b0));
    end
    req = 4'b0;
    tick();
  endtask

  task automatic test_rotation();
    logic [3:0] g;
    do_reset();
    req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      g = 4'(1 << (k % 4));
      tests++;
      if (obs !== exp_of(g, 1'b0)) begin
        fails++; $display("FAIL rotation_first k=%0d: got %b want %b", k, obs, exp_of(g, 1'b0));
      end
      req = 4'b1111;
      tick();
      tests++;
      if (obs !== exp_of(g, 1'b0)) begin
        fails++; $display("FAIL rotation_second k=%0d: got %b want %b", k, obs, exp_of(g, 1'b0));
      end
      req = 4'b1111 & ~g;
      tick();
    end
    req = 4'b0;
    tick(); tick();
  endtask

  task automatic test_watchdog();
    do_reset();
    req = 4'b0011;
    tick();
    for (int i = 0; i < MH; i++) begin
      tests++;
      if (obs !== exp_of(4'b0001, 1'b0)) begin
        fails++; $display("FAIL wd_hold cyc=%0d: got %b want %b", i, obs, exp_of(4'b0001, 1'b0));
      end
      tick();
    end
    tests++;
    if (obs !== exp_of(4'b0010, 1'b1)) begin
      fails++; $display("FAIL wd_force: got %b want %b", obs, exp_of(4'b0010, 1'b1));
    end
    tick();
    tests++;
    if (obs !== exp_of(4'b0010, 1'b0)) begin
      fails++; $display("FAIL wd_pulse_end: got %b want %b", obs, exp_of(4'b0010, 1'b0));
    end
    req = 4'b0001;
    tick();
    tests++;
    if (obs !== exp_of(4'b0001, 1'b0)) begin
      fails++; $display("FAIL wd_handover: got %b want %b", obs, exp_of(4'b0001, 1'b0));
    end
    for (int i = 1; i < MH; i++) tick();
    tick();
    tests++;
    if (obs !== exp_of(4'b0001, 1'b1)) begin
      fails++; $display("FAIL wd_regrant: got %b want %b", obs, exp_of(4'b0001, 1'b1));
    end
    req = 4'b0;
    tick(); tick();
  endtask

  task automatic test_enable();
    do_reset();
    en = 1'b0; req = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (obs !== 8'b0) begin
        fails++; $display("FAIL en_block: got %b want %b", obs, 8'b0);
      end
    end
    en = 1'b1;
    tick();
    tests++;
    if (obs !== exp_of(4'b1000, 1'b0)) begin
      fails++; $display("FAIL en_raise: got %b want %b", obs, exp_of(4'b1000, 1'b0));
    end
    en = 1'b0; req = 4'b1110;
    tick();
    tests++;
    if (obs !== exp_of(4'b1000, 1'b0)) begin
      fails++; $display("FAIL en_low_busy: got %b want %b", obs, exp_of(4'b1000, 1'b0));
    end
    req = 4'b0110;
    tick();
    tests++;
    if (obs !== 8'b0) begin
      fails++; $display("FAIL en_low_release: got %b want %b", obs, 8'b0);
    end
    en = 1'b1; req = 4'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0010;
    tick();
    tests++;
    if (obs !== exp_of(4'b0010, 1'b0)) begin
      fails++; $display("FAIL mid_grant: got %b want %b", obs, exp_of(4'b0010, 1'b0));
    end
    rst = 1'b1; req = 4'b1111;
    tick();
    tests++;
    if (obs !== 8'b0) begin
      fails++; $display("FAIL mid_reset: got %b want %b", obs, 8'b0);
    end
    rst = 1'b0;
    tick();
    tests++;
    if (obs !== exp_of(4'b0001, 1'b0)) begin
      fails++; $display("FAIL mid_after: got %b want %b", obs, exp_of(4'b0001, 1'b0));
    end
    req = 4'b0;
    tick();
  endtask

  task automatic test_random();
    logic [7:0] want;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(23) == 0) req[b] = ~req[b];
      en  = ($urandom_range(9) != 0);
      rst = ($urandom_range(599) == 0);
      tick();
      want = exp_of(model_gnt(), m_to);
      tests++;
      if (obs !== want) begin
        fails++; $display("FAIL random cyc=%0d req=%b: got %b want %b", c, req, obs, want);
      end
    end
    rst = 1'b0; req = 4'b0; en = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; req = 4'b0;
    test_reset();
    test_single();
    test_rotation();
    test_watchdog();
    test_enable();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
